// File: rtl/grid_io_param.sv
// IO grid tile: NUM_IO pad channels configured through a serial chain with a
// separate committed configuration, optional output register and input synchronizer.
module grid_io_param #(
  parameter int NUM_IO      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_head,
  input  logic              cfg_shift_en,
  input  logic              cfg_commit,
  output logic              cfg_tail,
  input  logic [NUM_IO-1:0] outpad,
  output logic [NUM_IO-1:0] inpad,
  input  logic [NUM_IO-1:0] gfpga_pad_in,
  output logic [NUM_IO-1:0] gfpga_pad_out,
  output logic [NUM_IO-1:0] gfpga_pad_oe
);

  localparam int CW = 3 * NUM_IO;

  logic [CW-1:0]                      chain_q, chain_d;
  logic [CW-1:0]                      active_q, active_d;
  logic [NUM_IO-1:0]                  oreg_q, oreg_d;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q, sync_d;

  // Commit samples chain_q, so a simultaneous shift still commits the pre-shift value.
  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    if (cfg_shift_en) chain_d = {chain_q[CW-2:0], cfg_head};
    if (cfg_commit) active_d = chain_q;
    oreg_d = outpad;
    sync_d = {sync_q[SYNC_STAGES-2:0], gfpga_pad_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q  <= '0;
      active_q <= '0;
      oreg_q   <= '0;
      sync_q   <= '0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      oreg_q   <= oreg_d;
      sync_q   <= sync_d;
    end
  end

  assign cfg_tail = chain_q[CW-1];

  // Output register and synchronizer run in every mode; the mode only selects.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    logic dir;
    logic oreg_en;
    logic ireg_en;

    assign dir     = active_q[3*i];
    assign oreg_en = active_q[3*i+1];
    assign ireg_en = active_q[3*i+2];

    assign gfpga_pad_oe[i]  = dir;
    assign gfpga_pad_out[i] = dir ? (oreg_en ? oreg_q[i] : outpad[i]) : 1'b0;
    assign inpad[i]         = dir ? 1'b0
                                  : (ireg_en ? sync_q[SYNC_STAGES-1][i] : gfpga_pad_in[i]);
  end

endmodule

// File: tb/tb_grid_io_param.sv
// Self-checking bench for grid_io_param (NUM_IO=8, SYNC_STAGES=2).
module tb_grid_io_param;
  localparam int W = 32;
  localparam int N = 8;
  localparam int S = 2;

  logic         clk;
  logic         reset_n;
  logic         cfg_head;
  logic         cfg_shift_en;
  logic         cfg_commit;
  logic         cfg_tail;
  logic [N-1:0] outpad;
  logic [N-1:0] inpad;
  logic [N-1:0] gfpga_pad_in;
  logic [N-1:0] gfpga_pad_out;
  logic [N-1:0] gfpga_pad_oe;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] hist_q[$];
  int n_cmp;
  int n_err;

  grid_io_param #(.NUM_IO(N), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_head     (cfg_head),
    .cfg_shift_en (cfg_shift_en),
    .cfg_commit   (cfg_commit),
    .cfg_tail     (cfg_tail),
    .outpad       (outpad),
    .inpad        (inpad),
    .gfpga_pad_in (gfpga_pad_in),
    .gfpga_pad_out(gfpga_pad_out),
    .gfpga_pad_oe (gfpga_pad_oe)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain image from per-channel DIR/OREG/IREG bytes.
  function automatic logic [3*N-1:0] pack(input logic [N-1:0] dir, input logic [N-1:0] oreg,
                                          input logic [N-1:0] ireg);
    logic [3*N-1:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      x[3*i]   = dir[i];
      x[3*i+1] = oreg[i];
      x[3*i+2] = ireg[i];
    end
    return x;
  endfunction

  // Driver tasks
  task automatic load_chain(input logic [3*N-1:0] bits);
    for (int k = 3*N-1; k >= 0; k--) begin
      @(negedge clk);
      cfg_head     = bits[k];
      cfg_shift_en = 1'b1;
    end
    @(negedge clk);
    cfg_shift_en = 1'b0;
    cfg_head     = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    reset_n      = 1'b0;
    cfg_head     = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    outpad       = 8'h5A;
    gfpga_pad_in = 8'hA5;
    @(negedge clk);
    #1;
    exp_q.push_back({24'h0, 8'h00, 8'h00, 8'hA5});
    e = exp_q.pop_front();
    n_cmp++;
    if ({8'h0, gfpga_pad_oe, gfpga_pad_out, inpad} !== e) begin
      n_err++;
      $display("FAIL reset_outputs: got oe/out/in %h expected %h",
               {8'h0, gfpga_pad_oe, gfpga_pad_out, inpad}, e);
    end
    n_cmp++;
    if (cfg_tail !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tail: got %b expected 0", cfg_tail);
    end
    reset_n = 1'b1;
    outpad  = 8'h00;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({gfpga_pad_oe, gfpga_pad_out, inpad, 7'b0, cfg_tail} !== {8'h00, 8'h00, 8'hA5, 8'h00}) begin
      n_err++;
      $display("FAIL after_reset: got oe %h out %h in %h tail %b expected 00 00 a5 0",
               gfpga_pad_oe, gfpga_pad_out, inpad, cfg_tail);
    end
  endtask

  task automatic test_chain();
    logic [23:0]  pat;
    logic [W-1:0] e;
    pat = 24'hC3A5F0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      exp_q.push_back((n <= 24) ? 32'h0 : {31'h0, pat[48-n]});
      cfg_head     = (n <= 24) ? pat[24-n] : 1'b0;
      cfg_shift_en = 1'b1;
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({31'h0, cfg_tail} !== e) begin
        n_err++;
        $display("FAIL chain_tail[%0d]: got %b expected %b", n, cfg_tail, e[0]);
      end
    end
    @(negedge clk);
    cfg_shift_en = 1'b0;
    cfg_head     = 1'b0;
    #1;
    n_cmp++;
    if (gfpga_pad_oe !== 8'h00) begin
      n_err++;
      $display("FAIL chain_no_commit_oe: got %h expected 00", gfpga_pad_oe);
    end
  endtask

  task automatic test_output_modes();
    logic [N-1:0] o;
    logic [N-1:0] p;
    logic [W-1:0] e;
    logic [W-1:0] h;
    outpad       = 8'h00;
    gfpga_pad_in = 8'hFF;
    load_chain(pack(8'h03, 8'h02, 8'h00));
    do_commit();
    #1;
    n_cmp++;
    if (gfpga_pad_oe !== 8'h03 || inpad[1:0] !== 2'b00) begin
      n_err++;
      $display("FAIL outmode_oe: got oe %h inpad[1:0] %b expected 03 00", gfpga_pad_oe, inpad[1:0]);
    end
    hist_q.delete();
    hist_q.push_back(32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      o = (c < 2) ? ((c == 0) ? 8'h03 : 8'h00) : 8'($urandom_range(0, 255));
      p = 8'($urandom_range(0, 255));
      outpad       = o;
      gfpga_pad_in = p;
      hist_q.push_back({31'h0, o[1]});
      h = hist_q.pop_front();
      exp_q.push_back({16'h0, 6'h0, h[0], o[0], p[7:2], 2'b00});
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({16'h0, gfpga_pad_out, inpad} !== e) begin
        n_err++;
        $display("FAIL outmode[%0d]: got out %h in %h expected out %h in %h",
                 c, gfpga_pad_out, inpad, e[15:8], e[7:0]);
      end
    end
    outpad = 8'h00;
  endtask

  task automatic test_input_sync();
    logic [N-1:0] p;
    logic [W-1:0] e;
    logic [W-1:0] s;
    gfpga_pad_in = 8'h00;
    load_chain(pack(8'h00, 8'h00, 8'h04));
    do_commit();
    #1;
    n_cmp++;
    if (gfpga_pad_oe !== 8'h00 || gfpga_pad_out !== 8'h00) begin
      n_err++;
      $display("FAIL insync_oe: got oe %h out %h expected 00 00", gfpga_pad_oe, gfpga_pad_out);
    end
    hist_q.delete();
    for (int k = 0; k < S; k++) hist_q.push_back(32'h0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      p = (c < 3) ? 8'h0C : 8'($urandom_range(0, 255));
      gfpga_pad_in = p;
      hist_q.push_back({31'h0, p[2]});
      s = hist_q.pop_front();
      exp_q.push_back({24'h0, p[7:3], s[0], p[1:0]});
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({24'h0, inpad} !== e) begin
        n_err++;
        $display("FAIL insync[%0d]: got %h expected %h", c, inpad, e[7:0]);
      end
    end
  endtask

  task automatic test_commit_shift();
    gfpga_pad_in = 8'hFF;
    outpad       = 8'hFF;
    load_chain(pack(8'h55, 8'h00, 8'hF0));
    @(negedge clk);
    cfg_commit   = 1'b1;
    cfg_shift_en = 1'b1;
    cfg_head     = 1'b0;
    @(negedge clk);
    cfg_commit   = 1'b0;
    cfg_shift_en = 1'b0;
    #1;
    n_cmp++;
    if ({gfpga_pad_oe, gfpga_pad_out, inpad} !== {8'h55, 8'h55, 8'hAA}) begin
      n_err++;
      $display("FAIL commit_shift_pre: got oe %h out %h in %h expected 55 55 aa",
               gfpga_pad_oe, gfpga_pad_out, inpad);
    end
    do_commit();
    #1;
    n_cmp++;
    if ({gfpga_pad_oe, gfpga_pad_out, inpad} !== {8'hE0, 8'hE0, 8'h1F}) begin
      n_err++;
      $display("FAIL commit_shift_post: got oe %h out %h in %h expected e0 e0 1f",
               gfpga_pad_oe, gfpga_pad_out, inpad);
    end
  endtask

  task automatic test_mid_reset();
    gfpga_pad_in = 8'h3C;
    outpad       = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cfg_head     = 1'b1;
      cfg_shift_en = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({gfpga_pad_oe, gfpga_pad_out, inpad, 7'b0, cfg_tail} !== {8'h00, 8'h00, 8'h3C, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset: got oe %h out %h in %h tail %b expected 00 00 3c 0",
               gfpga_pad_oe, gfpga_pad_out, inpad, cfg_tail);
    end
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    cfg_shift_en = 1'b0;
    cfg_head     = 1'b0;
    load_chain(pack(8'h0F, 8'h0A, 8'h00));
    do_commit();
    #1;
    n_cmp++;
    if ({gfpga_pad_oe, gfpga_pad_out, inpad} !== {8'h0F, 8'h0F, 8'h30}) begin
      n_err++;
      $display("FAIL reload: got oe %h out %h in %h expected 0f 0f 30",
               gfpga_pad_oe, gfpga_pad_out, inpad);
    end
    @(negedge clk);
    outpad = 8'h00;
    #1;
    n_cmp++;
    if (gfpga_pad_out !== 8'h0A) begin
      n_err++;
      $display("FAIL reload_oreg_hold: got %h expected 0a", gfpga_pad_out);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (gfpga_pad_out !== 8'h00) begin
      n_err++;
      $display("FAIL reload_oreg_next: got %h expected 00", gfpga_pad_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_chain();
    test_output_modes();
    test_input_sync();
    test_commit_shift();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grid_io_param.md
GRID_IO_PARAM -- requirements
Module: grid_io_param

Interface
- REQ-001: Parameter NUM_IO, default 8: number of IO subtiles (channels); legal range 1..32.
- REQ-002: Parameter SYNC_STAGES, default 2: input synchronizer depth when input registering is enabled; legal range 2..4.
- REQ-003: clk, input, 1: single clock for all sequential logic.
- REQ-004: reset_n, input, 1: reset, asynchronous assert, active-low.
- REQ-005: cfg_head, input, 1: configuration chain serial data in.
- REQ-006: cfg_shift_en, input, 1: shift configuration chain one position this cycle.
- REQ-007: cfg_commit, input, 1: copy chain contents into active configuration this cycle.
- REQ-008: cfg_tail, output, 1: configuration chain serial data out (last chain bit).
- REQ-009: outpad, input, NUM_IO: fabric-to-pad data; bit i belongs to channel i.
- REQ-010: inpad, output, NUM_IO: pad-to-fabric data.
- REQ-011: gfpga_pad_in, input, NUM_IO: value sampled from the physical pad.
- REQ-012: gfpga_pad_out, output, NUM_IO: value driven to the physical pad.
- REQ-013: gfpga_pad_oe, output, NUM_IO: pad output enable; 1 = drive the pad.

Function
- REQ-014: The configuration chain SHALL be a 3*NUM_IO-bit shift register; on a cfg_shift_en cycle, chain[0] <= cfg_head and chain[k] <= chain[k-1].
- REQ-015: cfg_tail SHALL equal chain[3*NUM_IO-1] combinationally from the register.
- REQ-016: Channel i config fields SHALL be: chain[3i] = DIR (1 = output), chain[3i+1] = OREG, chain[3i+2] = IREG.
- REQ-017: Active configuration SHALL be a separate 3*NUM_IO-bit register, loaded from the chain only on a cfg_commit cycle; shifting alone SHALL NOT change pad behaviour.
- REQ-018: If cfg_commit and cfg_shift_en are both high, active config SHALL capture the pre-shift chain value, and the chain SHALL still shift.
- REQ-019: gfpga_pad_oe[i] SHALL equal active DIR[i].
- REQ-020: DIR=1, OREG=0: gfpga_pad_out[i] = outpad[i] combinationally (0 cycles).
- REQ-021: DIR=1, OREG=1: gfpga_pad_out[i] = outpad[i] registered (1 cycle latency).
- REQ-022: DIR=0: gfpga_pad_out[i] SHALL be 0; the output register SHALL still track outpad[i].
- REQ-023: DIR=0, IREG=0: inpad[i] = gfpga_pad_in[i] combinationally.
- REQ-024: DIR=0, IREG=1: inpad[i] = gfpga_pad_in[i] through SYNC_STAGES flops (SYNC_STAGES cycle latency); the synchronizer SHALL run continuously regardless of mode.
- REQ-025: DIR=1: inpad[i] SHALL be 0.
- REQ-026: A mode change via commit SHALL take effect on the cycle after the commit edge; register contents SHALL NOT be cleared by the mode change, so switching OREG 0->1 presents the already-registered outpad value.
- REQ-027: Channels SHALL be fully independent; no cross-channel logic other than the shared chain.

Reset
- REQ-028: reset_n low SHALL asynchronously clear the chain, active config, output registers and synchronizer flops to 0.
- REQ-029: During and after reset: gfpga_pad_oe = 0, gfpga_pad_out = 0, cfg_tail = 0, and all channels in combinational-input mode (inpad = gfpga_pad_in).
- REQ-030: Reset asserted mid-shift or on a commit cycle SHALL discard the partial load; the first edge after reset_n rises SHALL operate normally.

Verification
- REQ-031: Reset: reset_n=0, gfpga_pad_in=8'hA5 -> gfpga_pad_oe=0, gfpga_pad_out=0, inpad=8'hA5, cfg_tail=0.
- REQ-032: Chain pass-through: shift 24 bits of pattern 0xC3A5F0 MSB first, then 24 more zeros -> cfg_tail reproduces the pattern MSB first starting on the 25th shift cycle; no gfpga_pad_oe change without commit.
- REQ-033: Output modes: load ch0 = DIR1/OREG0, ch1 = DIR1/OREG1, commit; toggle outpad[1:0] -> gfpga_pad_out[0] follows same cycle, gfpga_pad_out[1] one cycle later; gfpga_pad_oe=8'h03, inpad[1:0]=0.
- REQ-034: Input sync: ch2 = DIR0/IREG1, commit; gfpga_pad_in[2] 0->1 -> inpad[2] rises exactly 2 clk edges later (SYNC_STAGES=2); ch3 combinational follows same cycle.
- REQ-035: Commit with shift: assert cfg_commit and cfg_shift_en together -> active config equals pre-shift chain; one further commit picks up the shifted value.
- REQ-036: Mid-operation reset: after a configured state, pulse reset_n low for half a cycle mid-shift -> all outputs return to REQ-029 values immediately; a fresh full load then works.
